// File: rtl/vector_chain_sequencer_pkg.sv
// Shared types and constants for the vector chain sequencer and its input buffer.
package vector_chain_sequencer_pkg;

    localparam int unsigned VCS_N          = 8;
    localparam int unsigned VCS_DATA_WIDTH = 32;
    localparam int unsigned VCS_MAX_CHAINS = 4;
    localparam int unsigned VCS_CHAIN_ID_W = $clog2(VCS_MAX_CHAINS);

    typedef logic [VCS_CHAIN_ID_W-1:0] chain_id_t;
    typedef logic [VCS_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [VCS_N-1:0]         vec_t;

    // Issue FSM encoding
    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t ISSUE = 1'b1;

    localparam logic [7:0] CFG_NUM_CHAINS_ID = 8'd0;

    // Zero means one chain; anything above the hardware limit saturates.
    function automatic logic [7:0] clamp_chains(input logic [7:0] data,
                                                input logic [7:0] max_chains);
        if (data == 8'd0) begin
            return 8'd1;
        end
        if (data > max_chains) begin
            return max_chains;
        end
        return data;
    endfunction

endpackage

// File: rtl/vector_chain_sequencer_fifo.sv
// Synchronous FIFO holding {eof, vector} entries; head is readable without a pop.
module vector_fifo #(
    parameter int unsigned WIDTH = 257,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign rdata_c = mem[rd_ptr];

    // Storage is data-only; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_chain_sequencer.sv
// Buffers trace vectors and replays each once per active chain (chainId 0..K-1)
// towards the vector-vector ALU; K is written over the shared config bus.
module vector_chain_sequencer
    import vector_chain_sequencer_pkg::*;
#(
    parameter int unsigned N                  = VCS_N,
    parameter int unsigned DATA_WIDTH         = VCS_DATA_WIDTH,
    parameter int unsigned MAX_CHAINS         = VCS_MAX_CHAINS,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter logic [7:0]  PERSONAL_CONFIG_ID = CFG_NUM_CHAINS_ID,
    parameter int unsigned INITIAL_NUM_CHAINS = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tracing,
    input  logic [7:0]                          configId,
    input  logic [7:0]                          configData,
    input  logic                                valid_in,
    input  logic                                eof_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
    output logic                                ready_out,
    output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0]       chainId_out,
    output logic                                valid_out,
    output logic                                eof_out,
    output logic                                overflow
);

    localparam int unsigned CID_W   = $clog2(MAX_CHAINS);
    localparam int unsigned K_W     = CID_W + 1;
    localparam int unsigned VEC_W   = N * DATA_WIDTH;
    localparam int unsigned ENTRY_W = VEC_W + 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic [K_W-1:0]               k_cfg;
    logic [ENTRY_W-1:0]           fifo_rdata_c;
    logic                         fifo_full_c;
    logic                         fifo_empty_c;
    logic [CNT_W-1:0]             fifo_count;
    logic                         push_c;
    logic                         pop_c;
    logic                         last_c;

    state_t                       state,      state_nxt;
    logic [CID_W-1:0]             idx,        idx_nxt;
    logic [K_W-1:0]               k_lat,      k_lat_nxt;
    logic [N-1:0][DATA_WIDTH-1:0] head_vec,   head_vec_nxt;
    logic                         head_eof,   head_eof_nxt;
    logic [N-1:0][DATA_WIDTH-1:0] vec_nxt;
    logic [CID_W-1:0]             chain_nxt;
    logic                         valid_nxt;
    logic                         eof_nxt;

    assign ready_out = !fifo_full_c;
    assign push_c    = valid_in && ready_out;
    assign last_c    = (K_W'(idx) == k_lat - K_W'(1));

    vector_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   ({eof_in, vector_in}),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .count   (fifo_count)
    );

    // Chain count register; only sampled when a new vector is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cfg <= K_W'(INITIAL_NUM_CHAINS);
        end else if (configId == PERSONAL_CONFIG_ID) begin
            k_cfg <= K_W'(clamp_chains(configData, 8'(MAX_CHAINS)));
        end
    end

    // Sticky drop flag: a valid vector arrived while the buffer was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (valid_in && (fifo_count == CNT_W'(FIFO_DEPTH))) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            k_lat       <= K_W'(1);
            head_vec    <= '0;
            head_eof    <= 1'b0;
            vector_out  <= '0;
            chainId_out <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            k_lat       <= k_lat_nxt;
            head_vec    <= head_vec_nxt;
            head_eof    <= head_eof_nxt;
            vector_out  <= vec_nxt;
            chainId_out <= chain_nxt;
            valid_out   <= valid_nxt;
            eof_out     <= eof_nxt;
        end
    end

    // Pausing (tracing=0) holds everything except the issue strobes.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        k_lat_nxt    = k_lat;
        head_vec_nxt = head_vec;
        head_eof_nxt = head_eof;
        vec_nxt      = vector_out;
        chain_nxt    = chainId_out;
        valid_nxt    = 1'b0;
        eof_nxt      = 1'b0;
        pop_c        = 1'b0;

        case (state)
            IDLE: begin
                if (tracing && !fifo_empty_c) begin
                    pop_c     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (tracing) begin
                    valid_nxt = 1'b1;
                    vec_nxt   = head_vec;
                    chain_nxt = idx;
                    eof_nxt   = head_eof && last_c;
                    if (last_c) begin
                        if (!fifo_empty_c) begin
                            pop_c = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + CID_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A pop loads the next vector and snapshots the configured chain count.
        if (pop_c) begin
            head_vec_nxt = fifo_rdata_c[VEC_W-1:0];
            head_eof_nxt = fifo_rdata_c[VEC_W];
            k_lat_nxt    = k_cfg;
            idx_nxt      = '0;
        end
    end

endmodule

// File: tb/tb_vector_chain_sequencer.sv
// Self-checking bench: directed sequences, a config table and a randomized scoreboard run.
module tb_vector_chain_sequencer;
    import vector_chain_sequencer_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MC = 4;
    localparam int unsigned FD = 4;

    logic       clk;
    logic       rst_n;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       valid_in;
    logic       eof_in;
    vec_t       vector_in;
    logic       ready_out;
    vec_t       vector_out;
    chain_id_t  chainId_out;
    logic       valid_out;
    logic       eof_out;
    logic       overflow;

    vector_chain_sequencer #(
        .N                  (N),
        .DATA_WIDTH         (DW),
        .MAX_CHAINS         (MC),
        .FIFO_DEPTH         (FD),
        .PERSONAL_CONFIG_ID (8'd0),
        .INITIAL_NUM_CHAINS (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .vector_in   (vector_in),
        .ready_out   (ready_out),
        .vector_out  (vector_out),
        .chainId_out (chainId_out),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int        cyc;
        chain_id_t chain;
        logic      eof;
        vec_t      vec;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        int         exp_k;
        logic       eof;
    } cfg_vec_t;

    beat_t    log_q[$];
    beat_t    exp_q[$];
    cfg_vec_t tbl[8];
    int       cyc    = 0;
    int       total  = 0;
    int       passed = 0;
    int       p_edge;
    int       gap;
    logic     ovf_exp;
    logic     prev_tr;

    task automatic chk_i(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic chk_v(input string name, input vec_t act, input vec_t req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // One clock; samples 1ns after the edge and logs any issued beat.
    task automatic tick();
        beat_t b;
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out) begin
            b.cyc   = cyc;
            b.chain = chainId_out;
            b.eof   = eof_out;
            b.vec   = vector_out;
            log_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic vec_t fill(input logic [31:0] v);
        vec_t r;
        for (int i = 0; i < int'(N); i++) r[i] = v;
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < int'(N); i++) r[i] = $urandom;
        return r;
    endfunction

    task automatic cfg(input logic [7:0] d);
        configId   = CFG_NUM_CHAINS_ID;
        configData = d;
        tick();
        configId   = 8'hFF;
        configData = 8'h00;
    endtask

    task automatic push(input vec_t v, input logic e);
        valid_in  = 1'b1;
        vector_in = v;
        eof_in    = e;
        tick();
        valid_in  = 1'b0;
        eof_in    = 1'b0;
    endtask

    // Expected beats for one vector replayed over k chains.
    task automatic add_exp(input vec_t v, input logic e, input int k);
        for (int c = 0; c < k; c++) begin
            beat_t b;
            b.cyc   = 0;
            b.chain = chain_id_t'(c);
            b.eof   = e && (c == k - 1);
            b.vec   = v;
            exp_q.push_back(b);
        end
    endtask

    task automatic cmp_stream(input string name, input bit contig);
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        chk_i({name, "_beats"}, log_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk_i($sformatf("%s_chain%0d", name, i), int'(log_q[i].chain), int'(exp_q[i].chain));
            chk_i($sformatf("%s_eof%0d", name, i), int'(log_q[i].eof), int'(exp_q[i].eof));
            chk_v($sformatf("%s_vec%0d", name, i), log_q[i].vec, exp_q[i].vec);
            if (contig) chk_i($sformatf("%s_cyc%0d", name, i), log_q[i].cyc - log_q[0].cyc, i);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Randomized run: every issued beat must match the next expected beat in order.
    task automatic consume_rnd();
        beat_t b;
        beat_t e;
        while (log_q.size() > 0) begin
            b = log_q.pop_front();
            chk_i("rnd_tracing_at_issue", int'(prev_tr), 1);
            if (exp_q.size() == 0) begin
                chk_i("rnd_unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk_i("rnd_chain", int'(b.chain), int'(e.chain));
                chk_i("rnd_eof", int'(b.eof), int'(e.eof));
                chk_v("rnd_vec", b.vec, e.vec);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        tracing    = 1'b1;
        configId   = 8'hFF;
        configData = 8'h00;
        valid_in   = 1'b0;
        eof_in     = 1'b0;
        vector_in  = '0;

        tbl[0] = '{8'd3,   3, 1'b1};
        tbl[1] = '{8'd0,   1, 1'b1};
        tbl[2] = '{8'd9,   4, 1'b1};
        tbl[3] = '{8'd2,   2, 1'b0};
        tbl[4] = '{8'd1,   1, 1'b0};
        tbl[5] = '{8'd4,   4, 1'b0};
        tbl[6] = '{8'd5,   4, 1'b1};
        tbl[7] = '{8'd255, 4, 1'b1};

        // Reset state
        #12;
        chk_i("rst_valid", int'(valid_out), 0);
        chk_i("rst_eof", int'(eof_out), 0);
        chk_i("rst_chain", int'(chainId_out), 0);
        chk_v("rst_vector", vector_out, '0);
        chk_i("rst_overflow", int'(overflow), 0);
        chk_i("rst_ready", int'(ready_out), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        log_q.delete();

        // K=3, single eof vector: latency 2 edges after the push
        cfg(8'd3);
        push(fill(32'h11), 1'b1);
        p_edge = cyc;
        idle(8);
        if (log_q.size() > 0) chk_i("k3_latency", log_q[0].cyc - p_edge, 2);
        else chk_i("k3_latency_no_beat", 0, 1);
        add_exp(fill(32'h11), 1'b1, 3);
        cmp_stream("k3", 1'b1);

        // K=2, three back-to-back vectors, no bubble
        cfg(8'd2);
        push(fill(32'hA), 1'b0);
        push(fill(32'hB), 1'b1);
        push(fill(32'hC), 1'b0);
        idle(10);
        add_exp(fill(32'hA), 1'b0, 2);
        add_exp(fill(32'hB), 1'b1, 2);
        add_exp(fill(32'hC), 1'b0, 2);
        cmp_stream("b2b", 1'b1);

        // Pause after chain 1 of a K=4 vector while two more are buffered
        cfg(8'd4);
        push(fill(32'h20), 1'b1);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) tick();
        chk_i("pause_reached", log_q.size(), 2);
        tracing = 1'b0;
        push(fill(32'h21), 1'b0);
        push(fill(32'h22), 1'b1);
        idle(3);
        chk_i("pause_quiet", log_q.size(), 2);
        chk_i("pause_valid", int'(valid_out), 0);
        tracing = 1'b1;
        idle(16);
        if (log_q.size() > 2) chk_i("pause_resume_gap", log_q[2].cyc - log_q[1].cyc, 6);
        else chk_i("pause_resume_missing", 0, 1);
        add_exp(fill(32'h20), 1'b1, 4);
        add_exp(fill(32'h21), 1'b0, 4);
        add_exp(fill(32'h22), 1'b1, 4);
        cmp_stream("pause", 1'b0);

        // K changed while a K=2 vector is already in the issue register
        cfg(8'd2);
        push(fill(32'h30), 1'b1);
        push(fill(32'h31), 1'b1);
        cfg(8'd4);
        idle(12);
        add_exp(fill(32'h30), 1'b1, 2);
        add_exp(fill(32'h31), 1'b1, 4);
        cmp_stream("cfg_mid", 1'b1);

        // Config clamp table: written value -> number of chains issued
        for (int i = 0; i < 8; i++) begin
            cfg(tbl[i].data);
            push(fill(32'hA0 + i), tbl[i].eof);
            idle(8);
            add_exp(fill(32'hA0 + i), tbl[i].eof, tbl[i].exp_k);
            cmp_stream($sformatf("tbl%0d", i), 1'b1);
        end

        // Overflow: five pushes into four slots while paused
        cfg(8'd1);
        tracing = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_i($sformatf("ovf_ready%0d", i), int'(ready_out), (i < 4) ? 1 : 0);
            if (i == 4) chk_i("ovf_pre", int'(overflow), 0);
            push(fill(32'hB0 + i), 1'b0);
        end
        chk_i("ovf_set", int'(overflow), 1);
        idle(2);
        chk_i("ovf_sticky", int'(overflow), 1);
        tracing = 1'b1;
        idle(10);
        for (int i = 0; i < 4; i++) add_exp(fill(32'hB0 + i), 1'b0, 1);
        cmp_stream("ovf_drain", 1'b1);
        chk_i("ovf_after_drain", int'(overflow), 1);

        // Reset mid-issue with two vectors buffered
        cfg(8'd3);
        push(fill(32'hC0), 1'b1);
        push(fill(32'hC1), 1'b1);
        push(fill(32'hC2), 1'b1);
        for (int i = 0; i < 10 && log_q.size() < 1; i++) tick();
        chk_i("rst_mid_reached", log_q.size(), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_i("rst_mid_valid", int'(valid_out), 0);
        chk_i("rst_mid_eof", int'(eof_out), 0);
        chk_i("rst_mid_chain", int'(chainId_out), 0);
        chk_v("rst_mid_vector", vector_out, '0);
        chk_i("rst_mid_ready", int'(ready_out), 1);
        chk_i("rst_mid_overflow", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        idle(10);
        chk_i("rst_mid_silent", log_q.size(), 0);
        push(fill(32'hCC), 1'b1);
        idle(5);
        add_exp(fill(32'hCC), 1'b1, 1);
        cmp_stream("rst_k_init", 1'b1);

        // Randomized traffic, one phase per chain count
        ovf_exp = 1'b0;
        for (int kk = 1; kk <= int'(MC); kk++) begin
            cfg(8'(kk));
            for (int c = 0; c < 150; c++) begin
                valid_in  = 1'($urandom_range(0, 1));
                eof_in    = 1'($urandom_range(0, 1));
                vector_in = rand_vec();
                tracing   = ($urandom_range(0, 3) != 0);
                if (valid_in) begin
                    if (ready_out) add_exp(vector_in, eof_in, kk);
                    else ovf_exp = 1'b1;
                end
                prev_tr = tracing;
                tick();
                consume_rnd();
            end
            valid_in = 1'b0;
            eof_in   = 1'b0;
            tracing  = 1'b1;
            prev_tr  = 1'b1;
            for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
                tick();
                consume_rnd();
            end
            chk_i($sformatf("rnd_k%0d_drained", kk), exp_q.size(), 0);
            idle(3);
            chk_i($sformatf("rnd_k%0d_extra", kk), log_q.size(), 0);
            chk_i($sformatf("rnd_k%0d_overflow", kk), int'(overflow), int'(ovf_exp));
            log_q.delete();
            exp_q.delete();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
